// File: rtl/pl_instruction_prefetch_if.sv
// pl_instruction_prefetch_if
// Groups the signals between the fetch stage, the decode stage and the
// instruction ROM.
//
// Handshake semantics (applies to if_valid/if_ready): an instruction transfers
// on a rising edge where if_valid & if_ready are both high. Once if_valid is
// high, pc, pc_next and instruction hold until the transfer happens, unless a
// redirect squashes the queue. if_valid does not depend on if_ready. The ROM
// side has no backpressure: every cycle with rom_req high is an accepted
// request, and every cycle with rom_rvalid high carries one response, in
// request order.
//
// Signals:
//   en, redirect, redirect_pc       : control from the program-counter logic
//   if_valid, if_ready, pc, pc_next,
//   instruction                     : head of the queue toward decode
//   rom_req, rom_addr               : fetch requests to the ROM
//   rom_rvalid, rom_rdata           : in-order ROM responses
// Modports: master = the prefetch stage, slave = its environment.
interface pl_instruction_prefetch_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  en;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  if_valid;
  logic                  if_ready;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [31:0]           instruction;
  logic                  rom_req;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_rvalid;
  logic [31:0]           rom_rdata;

  modport master (
    input  en, redirect, redirect_pc, if_ready, rom_rvalid, rom_rdata,
    output if_valid, pc, pc_next, instruction, rom_req, rom_addr
  );

  modport slave (
    output en, redirect, redirect_pc, if_ready, rom_rvalid, rom_rdata,
    input  if_valid, pc, pc_next, instruction, rom_req, rom_addr
  );
endinterface

// File: rtl/pl_instruction_prefetch.sv
// pl_instruction_prefetch
// Instruction-fetch stage with a DEPTH-entry prefetch queue. Issues sequential
// word fetches to an in-order, variable-latency ROM, buffers the returned
// words and presents them to decode over a valid/ready handshake. A one-cycle
// redirect empties the queue, reloads the fetch PC and arranges for all
// responses still owed by the ROM to be dropped.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : pl_instruction_prefetch_if master modport (control, decode side,
//         ROM side)
// Parameters:
//   ADDR_WIDTH : PC / ROM address width
//   DEPTH      : queue entries (power of two, >= 2); also the cap on
//                queued + in-flight fetches
//   RESET_PC   : fetch address after reset (word aligned)
module pl_instruction_prefetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input logic                       clk,
  input logic                       rst,
  pl_instruction_prefetch_if.master bus
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [31:0]           mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         discard;

  logic                  issue;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic                  if_valid_i;
  logic [CW:0]           credit_used;
  logic [CW:0]           stale_total;
  logic [CW:0]           discard_next;
  logic [ADDR_WIDTH-1:0] redirect_target;

  // Every queued word plus every live outstanding fetch holds one credit, so
  // a response can always be written without checking for a full queue.
  assign credit_used = {1'b0, count} + {1'b0, inflight};
  assign issue       = bus.en & ~bus.redirect & (credit_used < (CW+1)'(DEPTH));

  // Stale responses are consumed before any live one: the ROM answers in
  // order, so everything issued before the last redirect returns first.
  assign drop        = bus.rom_rvalid & (discard != '0);
  assign push        = bus.rom_rvalid & (discard == '0) & (inflight != '0);

  assign if_valid_i  = (count != '0) & ~bus.redirect;
  assign pop         = if_valid_i & bus.if_ready;

  assign redirect_target = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  // On redirect all live in-flight fetches become stale. A response arriving
  // in the redirect cycle itself is dropped right away, so it is not counted.
  // The guard keeps a spurious response with nothing owed from wrapping.
  assign stale_total  = {1'b0, discard} + {1'b0, inflight};
  assign discard_next = stale_total -
                        (CW+1)'(bus.rom_rvalid && (stale_total != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= redirect_target;
      head_pc  <= redirect_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= discard_next[CW-1:0];
    end else begin
      if (issue) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      if (push)  wr_ptr   <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        head_pc <= head_pc + ADDR_WIDTH'(4);
      end
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(issue) - CW'(push);
      discard  <= discard - CW'(drop);
    end
  end

  // Queue storage carries no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !bus.redirect) mem[wr_ptr] <= bus.rom_rdata;
  end

  assign bus.if_valid    = if_valid_i;
  assign bus.pc          = head_pc;
  assign bus.pc_next     = head_pc + ADDR_WIDTH'(4);
  assign bus.instruction = if_valid_i ? mem[rd_ptr] : NOP;
  assign bus.rom_req     = issue;
  assign bus.rom_addr    = fetch_pc;

endmodule

// File: tb/tb_pl_instruction_prefetch.sv
// tb_pl_instruction_prefetch
// Randomized bench for pl_instruction_prefetch. A ROM model answers requests
// in order after a random latency; a reference model tracks, per redirect
// epoch, how many fetches were issued, which words came back and which were
// consumed, and derives every expected output from that.
module tb_pl_instruction_prefetch;

  localparam int          AW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pl_instruction_prefetch_if #(.ADDR_WIDTH(AW)) bus ();

  pl_instruction_prefetch #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  req_t        rom_q[$];  // requests the ROM still owes
  logic [31:0] exp_q[$];  // addresses of live words buffered in the queue
  int          cyc;
  int          epoch;
  int          last_due;
  int          issued;    // live requests since the last redirect/reset
  int          popped;    // words consumed since the last redirect/reset
  int          n_pops;
  int          n_redirects;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;

  int lmin, lmax, ready_pct, redir_pct, en_pct;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C96_A55A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rom_q.delete();
    exp_q.delete();
    issued    = 0;
    popped    = 0;
    exp_pc    = RESET_PC;
    exp_fetch = RESET_PC;
    last_due  = -1;
    epoch++;
  endtask

  task automatic idle_inputs();
    bus.en          = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.if_ready    = 1'b0;
    bus.rom_rvalid  = 1'b0;
    bus.rom_rdata   = '0;
  endtask

  task automatic check_reset_values(input string sfx);
    check({"rst_rom_req", sfx},     {31'b0, bus.rom_req},  32'd0);
    check({"rst_rom_addr", sfx},    bus.rom_addr,           RESET_PC);
    check({"rst_if_valid", sfx},    {31'b0, bus.if_valid}, 32'd0);
    check({"rst_pc", sfx},          bus.pc,                 RESET_PC);
    check({"rst_pc_next", sfx},     bus.pc_next,            RESET_PC + 32'd4);
    check({"rst_instruction", sfx}, bus.instruction,        NOP);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic do_cycle();
    req_t        r;
    req_t        nr;
    logic        resp;
    logic        live_push;
    logic        exp_valid;
    logic        exp_req;
    logic [31:0] rpc;
    int          due;

    @(negedge clk);
    bus.en       = (int'($urandom_range(99)) < en_pct);
    bus.if_ready = (int'($urandom_range(99)) < ready_pct);
    bus.redirect = (int'($urandom_range(99)) < redir_pct);
    rpc = $urandom();
    // bias some targets to the top of the address space to exercise wrap
    if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFE0 | 32'($urandom_range(31));
    bus.redirect_pc = rpc;
    resp = (rom_q.size() != 0) && (rom_q[0].due == cyc);
    bus.rom_rvalid = resp;
    bus.rom_rdata  = resp ? rom_word(rom_q[0].addr) : $urandom();
    #1;

    exp_valid = (exp_q.size() != 0) && !bus.redirect;
    exp_req   = bus.en && !bus.redirect && ((issued - popped) < DEPTH);

    check("if_valid",    {31'b0, bus.if_valid}, {31'b0, exp_valid});
    check("pc",          bus.pc,                exp_pc);
    check("pc_next",     bus.pc_next,           exp_pc + 32'd4);
    check("instruction", bus.instruction,
          exp_valid ? rom_word(exp_q[0]) : NOP);
    check("rom_req",     {31'b0, bus.rom_req},  {31'b0, exp_req});
    if (exp_req) check("rom_addr", bus.rom_addr, exp_fetch);

    // ---- scoreboard / model update for the coming edge ----
    live_push = 1'b0;
    r.addr = '0; r.due = 0; r.epoch = 0;
    if (resp) begin
      r = rom_q.pop_front();
      live_push = !bus.redirect && (r.epoch == epoch);
    end

    if (bus.redirect) begin
      epoch++;
      exp_q.delete();
      issued    = 0;
      popped    = 0;
      exp_pc    = {rpc[31:2], 2'b00};
      exp_fetch = {rpc[31:2], 2'b00};
      n_redirects++;
    end else begin
      if (exp_valid && bus.if_ready) begin
        void'(exp_q.pop_front());
        popped++;
        n_pops++;
        exp_pc = exp_pc + 32'd4;
      end
      if (live_push) exp_q.push_back(r.addr);
      if (exp_req) begin
        due = cyc + int'($urandom_range(lmax, lmin));
        if (due <= last_due) due = last_due + 1;
        nr.addr  = exp_fetch;
        nr.due   = due;
        nr.epoch = epoch;
        rom_q.push_back(nr);
        last_due  = due;
        issued++;
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run_phase(input int l0, input int l1, input int rdy,
                           input int rdr, input int en_p, input int n);
    lmin = l0; lmax = l1; ready_pct = rdy; redir_pct = rdr; en_pct = en_p;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  // Reset asserted between clock edges; outputs must follow at once.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    check_reset_values("_mid");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    epoch       = 0;
    cyc         = 0;
    n_pops      = 0;
    n_redirects = 0;
    rst         = 1'b1;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("");
    rst = 1'b0;

    // steady stream, L=1, decode always ready
    run_phase(1, 1, 100, 0, 100, 40);
    // decode stalled: issue must stop once DEPTH credits are used
    run_phase(1, 1, 0, 0, 100, 12);
    // release: drain back to back and resume issuing
    run_phase(1, 1, 100, 0, 100, 20);
    // L=3 with occasional redirects
    run_phase(3, 3, 100, 5, 100, 300);
    // mixed latency, stalls, enable gaps, frequent redirects
    run_phase(1, 6, 60, 8, 80, 1500);
    run_phase(2, 5, 30, 3, 90, 1000);
    // long latency beyond the queue depth
    run_phase(6, 6, 100, 1, 100, 300);
    // fill the queue, then reset mid-stream
    run_phase(1, 2, 0, 0, 100, 15);
    async_reset();
    run_phase(1, 1, 100, 0, 100, 10);
    run_phase(1, 4, 70, 5, 90, 800);

    check("progress_pops", {31'b0, n_pops > 1000}, 32'd1);
    check("progress_redirects", {31'b0, n_redirects > 50}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
